field_index_decoder: RTL

Inverse of the mine/field overlay mapping: converts a screen pixel position (typically the mouse cursor) into 1-based board field indices `ind_x`/`ind_y`, using the same geometry as the overlay drawers (`board_xpos`, `board_ypos`, `button_size`, field N at offset `(N-1)*button_size`). It sits between the mouse position path and the game-logic/board-memory blocks. It uses an iterative subtract-based divider under a small FSM with a request/valid handshake.

---
 rtl/field_index_decoder.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/field_index_decoder.sv
// rtl/field_index_decoder.sv - screen position to 1-based board field index via iterative divider
module field_index_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  level,
  input  logic [4:0]  field_count,
  input  logic [6:0]  button_size,
  input  logic [10:0] board_xpos,
  input  logic [10:0] board_ypos,
  input  logic [10:0] xpos,
  input  logic [10:0] ypos,
  input  logic        req,
  output logic        busy,
  output logic        valid,
  output logic        in_board,
  output logic [4:0]  ind_x,
  output logic [4:0]  ind_y
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    DIV_X = 3'd2,
    DIV_Y = 3'd3,
    DONE  = 3'd4
  } state_t;

  state_t state, state_nxt;

  // Query snapshot, taken when the request is accepted so later input
  // changes cannot disturb the query in flight.
  logic [1:0]  lvl_q,  lvl_nxt;
  logic [4:0]  fc_q,   fc_nxt;
  logic [6:0]  bs_q,   bs_nxt;
  logic [10:0] bx_q,   bx_nxt;
  logic [10:0] by_q,   by_nxt;
  logic [10:0] x_q,    x_nxt;
  logic [10:0] y_q,    y_nxt;

  // Divider working registers: remainders and 1-based quotient accumulators.
  logic [10:0] rem_x,  rem_x_nxt;
  logic [10:0] rem_y,  rem_y_nxt;
  logic [4:0]  acc_x,  acc_x_nxt;
  logic [4:0]  acc_y,  acc_y_nxt;

  logic        busy_nxt;
  logic        valid_nxt;
  logic        in_board_nxt;
  logic [4:0]  ind_x_nxt;
  logic [4:0]  ind_y_nxt;

  // Geometry helpers derived from the snapshot.
  logic [11:0] span;
  logic [10:0] dx;
  logic [10:0] dy;
  logic [10:0] bs_ext;
  logic        out_of_board;

  assign span   = 12'(fc_q) * 12'(bs_q);
  assign dx     = x_q - bx_q;
  assign dy     = y_q - by_q;
  assign bs_ext = {4'd0, bs_q};

  // dx/dy are only meaningful when no underflow occurred, which the
  // x_q < bx_q / y_q < by_q terms cover before the span comparison matters.
  assign out_of_board = (lvl_q == 2'd0) || (bs_q == 7'd0) || (fc_q == 5'd0) ||
                        (x_q < bx_q) || (y_q < by_q) ||
                        ({1'b0, dx} >= span) || ({1'b0, dy} >= span);

  // Next-state and next-register logic for the decoder FSM.
  always_comb begin
    state_nxt    = state;
    lvl_nxt      = lvl_q;
    fc_nxt       = fc_q;
    bs_nxt       = bs_q;
    bx_nxt       = bx_q;
    by_nxt       = by_q;
    x_nxt        = x_q;
    y_nxt        = y_q;
    rem_x_nxt    = rem_x;
    rem_y_nxt    = rem_y;
    acc_x_nxt    = acc_x;
    acc_y_nxt    = acc_y;
    valid_nxt    = 1'b0;
    in_board_nxt = in_board;
    ind_x_nxt    = ind_x;
    ind_y_nxt    = ind_y;

    case (state)
      IDLE: begin
        if (req) begin
          lvl_nxt   = level;
          fc_nxt    = field_count;
          bs_nxt    = button_size;
          bx_nxt    = board_xpos;
          by_nxt    = board_ypos;
          x_nxt     = xpos;
          y_nxt     = ypos;
          state_nxt = CHECK;
        end
      end

      CHECK: begin
        if (out_of_board) begin
          in_board_nxt = 1'b0;
          ind_x_nxt    = 5'd0;
          ind_y_nxt    = 5'd0;
          valid_nxt    = 1'b1;
          state_nxt    = DONE;
        end else begin
          rem_x_nxt = dx;
          rem_y_nxt = dy;
          acc_x_nxt = 5'd1;
          acc_y_nxt = 5'd1;
          state_nxt = DIV_X;
        end
      end

      DIV_X: begin
        if (rem_x >= bs_ext) begin
          rem_x_nxt = rem_x - bs_ext;
          acc_x_nxt = acc_x + 5'd1;
        end else begin
          state_nxt = DIV_Y;
        end
      end

      DIV_Y: begin
        if (rem_y >= bs_ext) begin
          rem_y_nxt = rem_y - bs_ext;
          acc_y_nxt = acc_y + 5'd1;
        end else begin
          in_board_nxt = 1'b1;
          ind_x_nxt    = acc_x;
          ind_y_nxt    = acc_y;
          valid_nxt    = 1'b1;
          state_nxt    = DONE;
        end
      end

      DONE: begin
        state_nxt = IDLE;
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  // State, snapshot, divider and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      lvl_q    <= 2'd0;
      fc_q     <= 5'd0;
      bs_q     <= 7'd0;
      bx_q     <= 11'd0;
      by_q     <= 11'd0;
      x_q      <= 11'd0;
      y_q      <= 11'd0;
      rem_x    <= 11'd0;
      rem_y    <= 11'd0;
      acc_x    <= 5'd0;
      acc_y    <= 5'd0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      in_board <= 1'b0;
      ind_x    <= 5'd0;
      ind_y    <= 5'd0;
    end else begin
      state    <= state_nxt;
      lvl_q    <= lvl_nxt;
      fc_q     <= fc_nxt;
      bs_q     <= bs_nxt;
      bx_q     <= bx_nxt;
      by_q     <= by_nxt;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      rem_x    <= rem_x_nxt;
      rem_y    <= rem_y_nxt;
      acc_x    <= acc_x_nxt;
      acc_y    <= acc_y_nxt;
      busy     <= busy_nxt;
      valid    <= valid_nxt;
      in_board <= in_board_nxt;
      ind_x    <= ind_x_nxt;
      ind_y    <= ind_y_nxt;
    end
  end

endmodule
